// File: rtl/atomic_mem_ctrl_pkg.sv
// Shared opcode and FSM encodings for the atomic memory-access stage.
package atomic_mem_ctrl_pkg;
  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_SWAP = 3'b010;
  localparam logic [2:0] OP_FADD = 3'b011;
  localparam logic [2:0] OP_LL   = 3'b100;
  localparam logic [2:0] OP_SC   = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;
endpackage

// File: rtl/atomic_mem_ctrl_ll_sc_reservation.sv
// Single LL/SC reservation: set by LL, consumed by SC, cleared by any write to the reserved word.
module ll_sc_reservation #(
  parameter int IDX_W = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             clr,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  output logic             res_match
);
  logic             res_vld;
  logic [IDX_W-1:0] res_idx;

  // A new LL takes priority over any clearing event in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      res_vld <= 1'b0;
      res_idx <= '0;
    end else if (set) begin
      res_vld <= 1'b1;
      res_idx <= req_idx;
    end else if (clr || (wr_en && (wr_idx == res_idx))) begin
      res_vld <= 1'b0;
    end
  end

  assign res_match = res_vld && (res_idx == req_idx);
endmodule

// File: rtl/atomic_mem_ctrl.sv
// Memory-access stage: LW/SW pass-through, SWAP/FADD as two-cycle read-modify-write, LL/SC reservation.
module atomic_mem_ctrl
  import atomic_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  state_t            state, state_nxt;
  logic              ld_rmw, ll_set, sc_clr, res_match;
  logic [DATA_W-1:0] old_p1, addr_p1, data_p1;
  logic [OP_W-1:0]   op_p1;

  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  ll_sc_reservation #(.IDX_W(DATA_W-2)) u_res (
    .clk      (clk),
    .reset    (reset),
    .set      (ll_set),
    .clr      (sc_clr),
    .req_idx  (req_addr[DATA_W-1:2]),
    .wr_en    (mem_we),
    .wr_idx   (mem_addr[DATA_W-1:2]),
    .res_match(res_match)
  );

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_addr   = req_addr;
    mem_wd     = '0;
    ld_rmw     = 1'b0;
    ll_set     = 1'b0;
    sc_clr     = 1'b0;
    // Reset forces idle outputs, which also suppresses a pending RMW write
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            case (req_op)
              OP_LW, OP_LL: begin
                resp_valid = 1'b1;
                resp_rdata = mem_rd;
                ll_set     = (req_op == OP_LL);
              end
              OP_SW: begin
                resp_valid = 1'b1;
                mem_we     = 1'b1;
                mem_wd     = req_wdata;
              end
              OP_SC: begin
                resp_valid = 1'b1;
                sc_clr     = 1'b1;
                if (res_match) begin
                  mem_we     = 1'b1;
                  mem_wd     = req_wdata;
                  resp_rdata = {{(DATA_W-1){1'b0}}, 1'b1};
                end
              end
              OP_SWAP, OP_FADD: begin
                stall     = 1'b1;
                ld_rmw    = 1'b1;
                state_nxt = RMW_WR;
              end
              default: ;
            endcase
          end
        end
        RMW_WR: begin
          mem_addr   = addr_p1;
          mem_we     = 1'b1;
          mem_wd     = (op_p1 == OP_FADD) ? wrap_add(old_p1, data_p1) : data_p1;
          resp_valid = 1'b1;
          resp_rdata = old_p1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Read cycle -> write cycle: hold old value and operands for the RMW write
  always_ff @(posedge clk) begin
    if (reset) begin
      old_p1  <= '0;
      addr_p1 <= '0;
      data_p1 <= '0;
      op_p1   <= '0;
    end else if (ld_rmw) begin
      old_p1  <= mem_rd;
      addr_p1 <= req_addr;
      data_p1 <= req_wdata;
      op_p1   <= req_op;
    end
  end
endmodule

// File: tb/tb_atomic_mem_ctrl.sv
// Directed bench for atomic_mem_ctrl with a small word memory model behind it.
module tb_atomic_mem_ctrl;
  localparam logic [2:0] LW = 3'b000, SW = 3'b001, SWAP = 3'b010,
                         FADD = 3'b011, LL = 3'b100, SC = 3'b101, NOP = 3'b110;

  logic        clk, reset, req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  int n_chk = 0;
  int n_fail = 0;

  atomic_mem_ctrl #(.DATA_W(32), .OP_W(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[7:2]] <= mem_wd;
    else if (bd_we) mem[bd_idx]        <= bd_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    #1;
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    drive(1'b0, LW, 32'h0, 32'h0);
    bd_we = 1'b1; bd_idx = idx; bd_data = val;
    tick();
    bd_we = 1'b0;
  endtask

  initial begin
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1;
    drive(1'b0, LW, 32'h44, 32'h0);
    tick();
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_rvld", {31'b0, resp_valid}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    chk("rst_addr", mem_addr, 32'h44);
    tick();
    reset = 1'b0;

    poke(6'd4, 32'hDEADBEEF);
    poke(6'd3, 32'd5);

    drive(1'b1, LW, 32'h10, 32'h0);
    chk("lw_rvld", {31'b0, resp_valid}, 32'h1);
    chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
    chk("lw_stall", {31'b0, stall}, 32'h0);
    chk("lw_we", {31'b0, mem_we}, 32'h0);
    tick();

    drive(1'b1, SW, 32'h08, 32'h1234);
    chk("sw_we", {31'b0, mem_we}, 32'h1);
    chk("sw_wd", mem_wd, 32'h1234);
    chk("sw_rvld", {31'b0, resp_valid}, 32'h1);
    chk("sw_stall", {31'b0, stall}, 32'h0);
    tick();
    drive(1'b1, LW, 32'h08, 32'h0);
    chk("sw_readback", resp_rdata, 32'h1234);
    tick();

    drive(1'b1, FADD, 32'h0C, 32'd7);
    chk("fadd_c0_stall", {31'b0, stall}, 32'h1);
    chk("fadd_c0_we", {31'b0, mem_we}, 32'h0);
    chk("fadd_c0_rvld", {31'b0, resp_valid}, 32'h0);
    tick();
    drive(1'b1, SW, 32'h30, 32'hBAD);
    chk("fadd_c1_we", {31'b0, mem_we}, 32'h1);
    chk("fadd_c1_addr", mem_addr, 32'h0C);
    chk("fadd_c1_wd", mem_wd, 32'd12);
    chk("fadd_c1_rdata", resp_rdata, 32'd5);
    chk("fadd_c1_rvld", {31'b0, resp_valid}, 32'h1);
    chk("fadd_c1_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("fadd_mem3", mem[3], 32'd12);
    chk("fadd_mem12", mem[12], 32'h0);

    poke(6'd3, 32'hFFFFFFFF);
    drive(1'b1, SWAP, 32'h0C, 32'hA5);
    chk("swap_c0_stall", {31'b0, stall}, 32'h1);
    tick();
    drive(1'b0, LW, 32'h0, 32'h0);
    chk("swap_c1_rdata", resp_rdata, 32'hFFFFFFFF);
    chk("swap_c1_wd", mem_wd, 32'hA5);
    tick();
    chk("swap_mem3", mem[3], 32'hA5);

    poke(6'd3, 32'hFFFFFFFF);
    drive(1'b1, FADD, 32'h0C, 32'd1);
    tick();
    drive(1'b0, LW, 32'h0, 32'h0);
    chk("wrap_rdata", resp_rdata, 32'hFFFFFFFF);
    chk("wrap_wd", mem_wd, 32'h0);
    tick();
    chk("wrap_mem3", mem[3], 32'h0);

    poke(6'd8, 32'h77);
    drive(1'b1, LL, 32'h20, 32'h0);
    chk("ll_rdata", resp_rdata, 32'h77);
    chk("ll_rvld", {31'b0, resp_valid}, 32'h1);
    tick();
    drive(1'b1, SC, 32'h20, 32'd9);
    chk("sc1_rdata", resp_rdata, 32'h1);
    chk("sc1_we", {31'b0, mem_we}, 32'h1);
    tick();
    chk("sc1_mem8", mem[8], 32'd9);
    drive(1'b1, SC, 32'h20, 32'd10);
    chk("sc2_rdata", resp_rdata, 32'h0);
    chk("sc2_we", {31'b0, mem_we}, 32'h0);
    chk("sc2_rvld", {31'b0, resp_valid}, 32'h1);
    tick();
    chk("sc2_mem8", mem[8], 32'd9);

    drive(1'b1, LL, 32'h20, 32'h0);
    tick();
    drive(1'b1, SW, 32'h20, 32'd3);
    tick();
    drive(1'b1, SC, 32'h20, 32'd4);
    chk("sc_after_sw", resp_rdata, 32'h0);
    chk("sc_after_sw_we", {31'b0, mem_we}, 32'h0);
    tick();

    drive(1'b1, LL, 32'h24, 32'h0);
    tick();
    drive(1'b1, SC, 32'h28, 32'd4);
    chk("sc_other_addr", resp_rdata, 32'h0);
    tick();

    drive(1'b1, LL, 32'h20, 32'h0);
    tick();
    drive(1'b1, SW, 32'h2C, 32'd1);
    tick();
    drive(1'b1, SC, 32'h20, 32'd6);
    chk("sc_after_sw_other", resp_rdata, 32'h1);
    tick();

    drive(1'b1, LL, 32'h20, 32'h0);
    tick();
    drive(1'b1, FADD, 32'h20, 32'd1);
    tick();
    drive(1'b0, LW, 32'h0, 32'h0);
    tick();
    drive(1'b1, SC, 32'h20, 32'd4);
    chk("sc_after_rmw", resp_rdata, 32'h0);
    tick();

    drive(1'b1, NOP, 32'h20, 32'd4);
    chk("nop_rvld", {31'b0, resp_valid}, 32'h0);
    chk("nop_we", {31'b0, mem_we}, 32'h0);
    chk("nop_stall", {31'b0, stall}, 32'h0);
    tick();

    poke(6'd5, 32'h50);
    drive(1'b1, LL, 32'h20, 32'h0);
    tick();
    drive(1'b1, SWAP, 32'h14, 32'h99);
    chk("rstrmw_c0_stall", {31'b0, stall}, 32'h1);
    tick();
    reset = 1'b1;
    drive(1'b0, LW, 32'h0, 32'h0);
    chk("rstrmw_we", {31'b0, mem_we}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("rstrmw_mem5", mem[5], 32'h50);
    chk("rstrmw_stall", {31'b0, stall}, 32'h0);
    chk("rstrmw_rvld", {31'b0, resp_valid}, 32'h0);
    tick();
    drive(1'b1, SC, 32'h20, 32'd4);
    chk("rstrmw_sc", resp_rdata, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
